// File: rtl/bcd_sched_pkg.sv
// Shared constants for the BCD conversion scheduler: widths, default latency, FSM encodings.
package bcd_sched_pkg;

    localparam int unsigned BIN_W        = 11;
    localparam int unsigned BCD_W        = 16;
    localparam int unsigned CONV_LAT_DEF = 28;

    localparam logic [1:0] StIdle    = 2'd0;
    localparam logic [1:0] StIssue   = 2'd1;
    localparam logic [1:0] StWait    = 2'd2;
    localparam logic [1:0] StCapture = 2'd3;

    // Magnitude of an 11-bit two's complement value; -1024 maps to 1024 (11'h400).
    function automatic logic [BIN_W-1:0] abs_bin(input logic [BIN_W-1:0] v);
        return v[BIN_W-1] ? (~v + 1'b1) : v;
    endfunction

endpackage

// File: rtl/bcd_rr_arbiter.sv
// Combinational round-robin picker: first pending channel at or above ptr_i, wrapping mod N_CH.
module bcd_rr_arbiter #(
    parameter int unsigned N_CH  = 4,
    parameter int unsigned PTR_W = $clog2(N_CH)
) (
    input  logic [N_CH-1:0]  pending_i,
    input  logic [PTR_W-1:0] ptr_i,
    output logic [PTR_W-1:0] grant_o,
    output logic             any_pending_o
);

    logic        found;
    int unsigned idx;

    always_comb begin
        grant_o = ptr_i;
        found   = 1'b0;
        idx     = 0;
        for (int unsigned off = 0; off < N_CH; off++) begin
            idx = 32'(ptr_i) + off;
            if (idx >= N_CH) begin
                idx = idx - N_CH;
            end
            if (!found && pending_i[idx[PTR_W-1:0]]) begin
                found   = 1'b1;
                grant_o = idx[PTR_W-1:0];
            end
        end
        any_pending_o = |pending_i;
    end

endmodule

// File: rtl/bcd_conv_scheduler.sv
// Shares one binary-to-BCD unit between N_CH requesters with round-robin grants.
// Optional signed inputs (magnitude + sign flag) via `define BCD_SCHED_SIGNED_EN.
module bcd_conv_scheduler
    import bcd_sched_pkg::*;
#(
    parameter int unsigned N_CH     = 4,
    parameter int unsigned CONV_LAT = CONV_LAT_DEF
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [N_CH-1:0]         req_i,
    input  logic [N_CH*BIN_W-1:0]   bin_i,
    output logic                    conv_start_o,
    output logic [BIN_W-1:0]        conv_bin_o,
    input  logic [BCD_W-1:0]        conv_bcd_i,
    output logic [N_CH*BCD_W-1:0]   bcd_out_o,
    output logic [N_CH-1:0]         bcd_valid_o,
    output logic [N_CH-1:0]         bcd_neg_o,
    output logic                    busy_o
);

    localparam int unsigned PTR_W = $clog2(N_CH);
    localparam int unsigned CNT_W = $clog2(CONV_LAT + 1);

    logic [1:0]       state_q, state_d;
    logic [N_CH-1:0]  pending_q, pending_d;
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic [PTR_W-1:0] grant_q, grant_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [BIN_W-1:0] conv_bin_q, conv_bin_d;
    logic             sign_q, sign_d;
    logic [BCD_W-1:0] bcd_q [N_CH];
    logic [BCD_W-1:0] bcd_d [N_CH];
    logic [N_CH-1:0]  valid_q, valid_d;
    logic [N_CH-1:0]  neg_q, neg_d;

    logic [BIN_W-1:0] bin_ch [N_CH];
    logic [BIN_W-1:0] bin_sel;
    logic [PTR_W-1:0] arb_grant;
    logic             arb_any;
    logic             grant_load;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        assign bin_ch[i]                     = bin_i[i*BIN_W +: BIN_W];
        assign bcd_out_o[i*BCD_W +: BCD_W]   = bcd_q[i];
    end

    bcd_rr_arbiter #(
        .N_CH  (N_CH),
        .PTR_W (PTR_W)
    ) u_arb (
        .pending_i     (pending_q),
        .ptr_i         (ptr_q),
        .grant_o       (arb_grant),
        .any_pending_o (arb_any)
    );

    assign bin_sel = bin_ch[arb_grant];

    always_comb begin
        state_d    = state_q;
        pending_d  = pending_q;
        ptr_d      = ptr_q;
        grant_d    = grant_q;
        cnt_d      = cnt_q;
        conv_bin_d = conv_bin_q;
        sign_d     = sign_q;
        bcd_d      = bcd_q;
        valid_d    = '0;
        neg_d      = neg_q;
        grant_load = 1'b0;

        unique case (state_q)
            StIdle: begin
                grant_load = arb_any;
            end
            StIssue: begin
                pending_d[grant_q] = 1'b0;
                cnt_d              = CNT_W'(1);
                state_d            = StWait;
            end
            StWait: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(CONV_LAT - 1)) begin
                    state_d = StCapture;
                end
            end
            StCapture: begin
                bcd_d[grant_q]   = conv_bcd_i;
                valid_d[grant_q] = 1'b1;
                neg_d[grant_q]   = sign_q;
                if (arb_any) begin
                    grant_load = 1'b1;
                end else begin
                    state_d = StIdle;
                end
            end
        endcase

        if (grant_load) begin
            state_d = StIssue;
            grant_d = arb_grant;
            ptr_d   = (arb_grant == PTR_W'(N_CH - 1)) ? '0 : arb_grant + 1'b1;
`ifdef BCD_SCHED_SIGNED_EN
            // Sign is captured with the grant so it always matches the converted magnitude.
            conv_bin_d = abs_bin(bin_sel);
            sign_d     = bin_sel[BIN_W-1];
`else
            conv_bin_d = bin_sel;
            sign_d     = 1'b0;
`endif
        end

        // New requests win over the ISSUE clear so a re-request is never lost.
        pending_d = pending_d | req_i;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= StIdle;
            pending_q  <= '0;
            ptr_q      <= '0;
            grant_q    <= '0;
            cnt_q      <= '0;
            conv_bin_q <= '0;
            sign_q     <= 1'b0;
            valid_q    <= '0;
            neg_q      <= '0;
            for (int i = 0; i < N_CH; i++) begin
                bcd_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            pending_q  <= pending_d;
            ptr_q      <= ptr_d;
            grant_q    <= grant_d;
            cnt_q      <= cnt_d;
            conv_bin_q <= conv_bin_d;
            sign_q     <= sign_d;
            valid_q    <= valid_d;
            neg_q      <= neg_d;
            bcd_q      <= bcd_d;
        end
    end

    assign conv_start_o = (state_q == StIssue);
    assign conv_bin_o   = conv_bin_q;
    assign bcd_valid_o  = valid_q;
    assign bcd_neg_o    = neg_q;
    assign busy_o       = (state_q != StIdle);

endmodule

// File: tb/tb_bcd_conv_scheduler.sv
// Scoreboard bench for bcd_conv_scheduler with a behavioural stand-in for the BCD conversion unit.
module tb_bcd_conv_scheduler;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  req = '0;
    logic [43:0] bin = '0;
    logic [15:0] conv_bcd = '0;
    logic        conv_start;
    logic [10:0] conv_bin;
    logic [63:0] bcd_out;
    logic [3:0]  bcd_valid;
    logic [3:0]  bcd_neg;
    logic        busy;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    typedef struct {
        int          ch;
        logic [15:0] val;
        int          cyc;
    } exp_t;

    typedef struct {
        int          cyc;
        logic [10:0] bin;
    } start_t;

    exp_t        exp_q[$];
    start_t      start_q[$];
    logic [63:0] shadow = '0;

    bcd_conv_scheduler #(
        .N_CH     (4),
        .CONV_LAT (28)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .req_i        (req),
        .bin_i        (bin),
        .conv_start_o (conv_start),
        .conv_bin_o   (conv_bin),
        .conv_bcd_i   (conv_bcd),
        .bcd_out_o    (bcd_out),
        .bcd_valid_o  (bcd_valid),
        .bcd_neg_o    (bcd_neg),
        .busy_o       (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [15:0] to_bcd(input logic [10:0] v);
        int x;
        x = int'(v);
        return {4'(x / 1000 % 10), 4'(x / 100 % 10), 4'(x / 10 % 10), 4'(x % 10)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Conversion unit stand-in: result appears 27 cycles after START, 16'hFFFF while busy.
    initial begin : unit_model
        int          u_cnt;
        logic [10:0] u_bin;
        logic        u_unstable;
        start_t      s;
        u_cnt      = 0;
        u_bin      = '0;
        u_unstable = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                u_cnt    = 0;
                conv_bcd = '0;
            end else begin
                if (u_cnt > 0) begin
                    if (conv_bin !== u_bin) u_unstable = 1'b1;
                    u_cnt--;
                    if (u_cnt == 0) begin
                        conv_bcd = to_bcd(u_bin);
                        check("conv_bin_stable", 64'(u_unstable), 0);
                    end
                end
                if (conv_start) begin
                    check("start_while_busy", 64'(u_cnt), 0);
                    if (start_q.size() == 0) begin
                        check("start_expected", 64'(start_q.size()), 1);
                    end else begin
                        s = start_q.pop_front();
                        check("start_cycle", 64'(cyc), 64'(s.cyc));
                        check("start_bin", 64'(conv_bin), 64'(s.bin));
                    end
                    u_bin      = conv_bin;
                    u_cnt      = 27;
                    u_unstable = 1'b0;
                    conv_bcd   = 16'hFFFF;
                end
            end
        end
    end

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && bcd_valid != '0) begin
                if (exp_q.size() == 0) begin
                    check("valid_expected", 64'(bcd_valid), 0);
                end else begin
                    e = exp_q.pop_front();
                    check("valid_onehot", 64'(bcd_valid), 64'(4'b0001 << e.ch));
                    check("valid_cycle", 64'(cyc), 64'(e.cyc));
                    shadow[e.ch*16 +: 16] = e.val;
                    check("bcd_out", bcd_out, shadow);
                    check("bcd_neg", 64'(bcd_neg), 0);
                end
            end
        end
    end

    task automatic push_conv(input int ch, input logic [15:0] val, input logic [10:0] b,
                             input int start_cyc);
        exp_t   e;
        start_t s;
        s.cyc = start_cyc;
        s.bin = b;
        start_q.push_back(s);
        e.ch  = ch;
        e.val = val;
        e.cyc = start_cyc + 29;
        exp_q.push_back(e);
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_busy"}, 64'(busy), 0);
        check({tag, "_bcd_out"}, bcd_out, 0);
        check({tag, "_valid"}, 64'(bcd_valid), 0);
        check({tag, "_start"}, 64'(conv_start), 0);
        check({tag, "_conv_bin"}, 64'(conv_bin), 0);
        check({tag, "_neg"}, 64'(bcd_neg), 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = '0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst    = 1'b0;
        shadow = '0;
        check_cleared("rst");
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || start_q.size() != 0) && n < 400) begin
            tick();
            n++;
        end
        if (exp_q.size() != 0 || start_q.size() != 0) begin
            check("drain_timeout", 64'(exp_q.size() + start_q.size()), 0);
            exp_q.delete();
            start_q.delete();
        end
        repeat (40) tick();
        check("idle_after", 64'(busy), 0);
    endtask

    initial begin : stimulus
        int r;

        // Single request on channel 1.
        do_reset();
        tick();
        r = cyc;
        bin[11 +: 11] = 11'd1234;
        req = 4'b0010;
        push_conv(1, 16'h1234, 11'd1234, r + 2);
        tick();
        req = '0;
        drain();

        // All four channels at once: grants 0,1,2,3 spaced 29 cycles.
        do_reset();
        bin = {11'd2047, 11'd999, 11'd9, 11'd0};
        tick();
        r = cyc;
        req = 4'b1111;
        push_conv(0, 16'h0000, 11'd0,    r + 2);
        push_conv(1, 16'h0009, 11'd9,    r + 31);
        push_conv(2, 16'h0999, 11'd999,  r + 60);
        push_conv(3, 16'h2047, 11'd2047, r + 89);
        tick();
        req = '0;
        drain();

        // Fairness: req[0] and req[2] held through the ISSUE of channel 2.
        do_reset();
        bin = {11'd0, 11'd15, 11'd0, 11'd7};
        tick();
        r = cyc;
        req = 4'b0101;
        push_conv(0, 16'h0007, 11'd7,  r + 2);
        push_conv(2, 16'h0015, 11'd15, r + 31);
        push_conv(0, 16'h0007, 11'd7,  r + 60);
        push_conv(2, 16'h0015, 11'd15, r + 89);
        repeat (32) tick();
        req = '0;
        drain();

        // Re-request on channel 3 during its own WAIT, bin changed mid-WAIT.
        do_reset();
        bin[33 +: 11] = 11'd100;
        tick();
        r = cyc;
        req = 4'b1000;
        push_conv(3, 16'h0100, 11'd100, r + 2);
        push_conv(3, 16'h0200, 11'd200, r + 31);
        tick();
        req = '0;
        repeat (9) tick();
        req = 4'b1000;
        tick();
        req = '0;
        repeat (4) tick();
        bin[33 +: 11] = 11'd200;
        drain();

        // Reset at WAIT counter 15 aborts the conversion, then a fresh request.
        do_reset();
        bin[0 +: 11] = 11'd500;
        tick();
        r = cyc;
        req = 4'b0001;
        start_q.push_back('{cyc: r + 2, bin: 11'd500});
        tick();
        req = '0;
        repeat (16) tick();
        rst = 1'b1;
        tick();
        rst    = 1'b0;
        shadow = '0;
        check_cleared("abort");
        bin[0 +: 11] = 11'd42;
        r = cyc;
        req = 4'b0001;
        push_conv(0, 16'h0042, 11'd42, r + 2);
        tick();
        req = '0;
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
